// File: rtl/noc_beat_sender_pkg.sv
// Shared NOC packet types and helpers for the beat sender and the future
// receive-side reassembler.
package noc_beat_sender_pkg;

  localparam int NOC_DATA_BYTES = 16;
  localparam int NOC_DATA_BITS  = 128;

  typedef struct packed {
    logic [NOC_DATA_BITS-1:0] data;
    logic [15:0]              length;
  } NOCDataH;

  typedef enum logic {IDLE, SEND} state_t;

  // Number of beats needed for a legal byte length at a given beat width.
  function automatic logic [4:0] beat_count(input logic [15:0] length,
                                            input int unsigned width);
    int unsigned bpb;
    int unsigned n;
    bpb = width / 8;
    n   = (32'(length) + bpb - 1) / bpb;
    return 5'(n);
  endfunction

endpackage

// File: rtl/noc_beat_sender.sv
// Serializes one NOCDataH packet per transaction into width-bit beats,
// beat 0 first, with last on the final beat and unused byte lanes zeroed.
module noc_beat_sender
  import noc_beat_sender_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_enq__ENA,
  input  logic [143:0]        in_enq_v,
  output logic                in_enq__RDY,
  output logic                out_enq__ENA,
  output logic [width-1:0]    out_enq_v,
  output logic                out_enq_last,
  input  logic                out_enq__RDY,
  output logic                busy,
  output logic [15:0]         dropCount,
  output logic                state_dbg
);

  // Handshake: a transfer happens on a rising edge where the producer's ENA
  // and the consumer's RDY are both 1; ENA is never raised without RDY, and
  // the payload is only meaningful in a transfer cycle.

  NOCDataH                  pkt;
  state_t                   state;
  logic [NOC_DATA_BITS-1:0] masked;
  logic [NOC_DATA_BITS-1:0] data_r;
  logic [width-1:0]         beat_r;
  logic [4:0]               beats_left;
  logic [15:0]              drop_r;
  logic                     len_ok;
  logic                     accept;
  logic                     xfer;

  assign pkt    = NOCDataH'(in_enq_v);
  assign len_ok = (pkt.length != 16'd0) && (pkt.length <= 16'(NOC_DATA_BYTES));

  // Bytes at or beyond the packet length are cleared once at load time so
  // every later beat, including the final partial one, comes out zero-padded.
  always_comb begin
    masked = pkt.data;
    for (int b = 0; b < NOC_DATA_BYTES; b++) begin
      if (16'(b) >= pkt.length) masked[b*8 +: 8] = 8'h00;
    end
  end

  assign in_enq__RDY  = nRST && ((state == IDLE) ||
                        ((state == SEND) && (beats_left == 5'd1) && out_enq__RDY));
  assign accept       = in_enq__ENA && in_enq__RDY;
  assign xfer         = (state == SEND) && out_enq__RDY;
  assign out_enq__ENA = xfer;
  assign out_enq_v    = beat_r;
  assign out_enq_last = (state == SEND) && (beats_left == 5'd1);
  assign busy         = (state == SEND);
  assign dropCount    = drop_r;
  assign state_dbg    = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      data_r     <= '0;
      beat_r     <= '0;
      beats_left <= '0;
      drop_r     <= '0;
    end else begin
      if (xfer) begin
        if (beats_left == 5'd1) begin
          state      <= IDLE;
          data_r     <= '0;
          beat_r     <= '0;
          beats_left <= '0;
        end else begin
          beat_r     <= data_r[width-1:0];
          data_r     <= data_r >> width;
          beats_left <= beats_left - 5'd1;
        end
      end
      // Accept only happens in IDLE or on a last-beat cycle, so a reload
      // here overrides the end-of-packet clear above.
      if (accept) begin
        if (len_ok) begin
          state      <= SEND;
          beat_r     <= masked[width-1:0];
          data_r     <= masked >> width;
          beats_left <= beat_count(pkt.length, width);
        end else if (drop_r != 16'hFFFF) begin
          drop_r <= drop_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_beat_sender.sv
// Self-checking bench for noc_beat_sender at width 32 with a beat scoreboard.
module tb_noc_beat_sender;

  localparam int W   = 32;
  localparam int BPB = W / 8;

  logic          clk;
  logic          nrst;
  logic          in_ena;
  logic [143:0]  in_v;
  logic          in_rdy;
  logic          out_ena;
  logic [W-1:0]  out_v;
  logic          out_last;
  logic          out_rdy;
  logic          busy;
  logic [15:0]   drop_count;
  logic          state_dbg;

  logic [W:0]    exp_q[$];
  logic [W:0]    got_q[$];
  int            beat_cyc[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            acc_cyc  = 0;

  localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DATA_B = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  noc_beat_sender #(.width(W)) dut (
    .CLK          (clk),
    .nRST         (nrst),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq_last (out_last),
    .out_enq__RDY (out_rdy),
    .busy         (busy),
    .dropCount    (drop_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboard monitor: every transferred beat must match the queue head
  always @(negedge clk) begin
    if (out_ena) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got v=%h last=%b, required no beat", out_v, out_last);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_v} !== e) begin
          n_fail++;
          $display("FAIL beat_data: got last=%b v=%h, required last=%b v=%h",
                   out_last, out_v, e[W], e[W-1:0]);
        end
      end
      got_q.push_back({out_last, out_v});
      beat_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] model_beat(input logic [127:0] d, input int len, input int k);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < BPB; j++) begin
      if (k * BPB + j < len) r[j*8 +: 8] = d[(k*BPB + j)*8 +: 8];
    end
    return r;
  endfunction

  // driver: wait for in_rdy, offer one packet, push its expected beats
  task automatic send_pkt(input logic [127:0] d, input int len);
    int n;
    int waited;
    waited = 0;
    forever begin
      @(posedge clk); #2;
      if (in_rdy) break;
      waited++;
      if (waited > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_rdy stayed 0 for %0d cycles, required 1", waited);
        return;
      end
    end
    if (len >= 1 && len <= 16) begin
      n = (len + BPB - 1) / BPB;
      for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), model_beat(d, len, k)});
    end
    in_v    = {d, 16'(len)};
    in_ena  = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_ena  = 1'b0;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    forever begin
      @(posedge clk); #3;
      if (exp_q.size() == 0) break;
      waited++;
      if (waited > 100) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    beat_cyc.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_ena = 1'b0; in_v = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_rdy, out_ena, out_last, out_v, busy, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b ena=%b last=%b v=%h busy=%b drop=%h, required all 0",
               in_rdy, out_ena, out_last, out_v, busy, drop_count);
    end
    nrst = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %b, required 1", in_rdy);
    end
  endtask

  task automatic test_full_packet();
    clear_log();
    send_pkt(DATA_A, 16);
    wait_drain();
    n_checks++;
    if (got_q.size() != 4 || got_q[0] !== {1'b0, 32'hCCDDEEFF} || got_q[1] !== {1'b0, 32'h8899AABB} ||
        got_q[2] !== {1'b0, 32'h44556677} || got_q[3] !== {1'b1, 32'h00112233}) begin
      n_fail++;
      $display("FAIL full_beats: got %0d beats, first=%h last=%h, required 4 beats CCDDEEFF..00112233",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0, got_q.size() > 3 ? got_q[3] : '0);
    end
    n_checks++;
    if (beat_cyc.size() != 4 || beat_cyc[0] != acc_cyc + 1 || beat_cyc[3] != acc_cyc + 4) begin
      n_fail++;
      $display("FAIL full_latency: first beat cycle %0d, required %0d",
               beat_cyc.size() > 0 ? beat_cyc[0] : -1, acc_cyc + 1);
    end
  endtask

  task automatic test_partial();
    clear_log();
    send_pkt(DATA_A, 5);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_busy_high: got %b, required 1", busy);
    end
    wait_drain();
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== {1'b0, 32'hCCDDEEFF} || got_q[1] !== {1'b1, 32'h000000BB}) begin
      n_fail++;
      $display("FAIL partial_beats: got %0d beats, second=%h, required 2 beats ending 1_000000BB",
               got_q.size(), got_q.size() > 1 ? got_q[1] : '0);
    end
    n_checks++;
    if (busy !== 1'b0 || out_last !== 1'b0 || out_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_idle: busy=%b last=%b ena=%b, required 0 0 0", busy, out_last, out_ena);
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    clear_log();
    send_pkt(DATA_A, 8);
    acc1 = acc_cyc;
    send_pkt(DATA_B, 8);
    wait_drain();
    n_checks++;
    if (beat_cyc.size() != 4 || beat_cyc[0] != acc1 + 1 || beat_cyc[3] != beat_cyc[0] + 3) begin
      n_fail++;
      $display("FAIL b2b_bubble: %0d beats, span %0d cycles, required 4 beats over 4 cycles",
               beat_cyc.size(), beat_cyc.size() == 4 ? beat_cyc[3] - beat_cyc[0] + 1 : -1);
    end
    n_checks++;
    if (beat_cyc.size() < 2 || acc_cyc != beat_cyc[1]) begin
      n_fail++;
      $display("FAIL b2b_rdy_on_last: second accept in cycle %0d, required cycle of beat 2 (%0d)",
               acc_cyc, beat_cyc.size() > 1 ? beat_cyc[1] : -1);
    end
  endtask

  task automatic test_stall();
    logic         pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] prev_v;
    logic         prev_last;
    int           done;
    clear_log();
    out_rdy = 1'b0;
    send_pkt(DATA_A, 16);
    done = 0;
    prev_v = '0; prev_last = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_rdy = pat[i];
      #1;
      n_checks++;
      if (out_ena !== pat[i] || in_rdy !== (pat[i] && done == 3)) begin
        n_fail++;
        $display("FAIL stall_strobes[%0d]: ena=%b in_rdy=%b, required %b %b",
                 i, out_ena, in_rdy, pat[i], pat[i] && done == 3);
      end
      if (i > 0 && !pat[i-1]) begin
        n_checks++;
        if (out_v !== prev_v || out_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold[%0d]: v=%h last=%b, required %h %b", i, out_v, out_last, prev_v, prev_last);
        end
      end
      prev_v = out_v; prev_last = out_last;
      if (pat[i]) done++;
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_drain();
    n_checks++;
    if (got_q.size() != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d beats busy=%b, required 4 beats busy=0", got_q.size(), busy);
    end
  endtask

  task automatic test_illegal_length();
    clear_log();
    send_pkt(DATA_A, 0);
    send_pkt(DATA_A, 17);
    send_pkt(DATA_A, 4);
    wait_drain();
    n_checks++;
    if (drop_count !== 16'd2) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, required 2", drop_count);
    end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 32'hCCDDEEFF}) begin
      n_fail++;
      $display("FAIL drop_beats: got %0d beats, first=%h, required 1 beat 1_CCDDEEFF",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_log();
    send_pkt(DATA_A, 16);
    @(posedge clk); #1;
    nrst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({in_rdy, out_ena, out_last, out_v, busy, drop_count, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%b ena=%b last=%b v=%h busy=%b drop=%h, required all 0",
               in_rdy, out_ena, out_last, out_v, busy, drop_count);
    end
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_discard: %0d beats seen busy=%b, required 1 beat busy=0", got_q.size(), busy);
    end
    clear_log();
    send_pkt(DATA_B, 16);
    wait_drain();
    n_checks++;
    if (got_q.size() != 4 || got_q[0] !== {1'b0, DATA_B[31:0]}) begin
      n_fail++;
      $display("FAIL midreset_restart: got %0d beats, first=%h, required 4 beats first 0_%h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0, DATA_B[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_partial();
    test_back_to_back();
    test_stall();
    test_illegal_length();
    test_reset_mid_packet();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
